// File: rtl/resta_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding.
package resta_pkg;

    localparam int unsigned StateW = 2;

    typedef enum logic [StateW-1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/bit_restador.sv
// Combinational 1-bit full subtractor: r = a - b - cin, cout is the borrow out.
module bit_restador (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic r,
    output logic cout
);

    assign r    = a ^ b ^ cin;
    assign cout = (~a & b) | (~a & cin) | (b & cin);

endmodule

// File: rtl/restador_serie.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock with start/done handshake.
// Optional signed-overflow output enabled by defining RESTA_OVF_EN.
module restador_serie
    import resta_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef RESTA_OVF_EN
    output logic             borrow,
    output logic             ovf
`else
    output logic             borrow
`endif
);

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_sh_q, b_sh_q, res_sh_q;
    logic [WIDTH-1:0] diff_q;
    logic             bff_q, borrow_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cell_r, cell_cout;
    logic             accept, last_bit;

    assign accept   = start && ((state_q == StIdle) || (state_q == StDone));
    assign last_bit = (state_q == StShift) && (cnt_q == CNT_W'(WIDTH - 1));

    bit_restador u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (bff_q),
        .r    (cell_r),
        .cout (cell_cout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StShift;
            StShift: if (last_bit) state_d = StDone;
            StDone:  state_d = accept ? StShift : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == StShift);
        done = (state_q == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            bff_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            a_sh_q <= a;
            b_sh_q <= b;
            bff_q  <= bin;
            cnt_q  <= '0;
        end else if (state_q == StShift) begin
            a_sh_q   <= a_sh_q >> 1;
            b_sh_q   <= b_sh_q >> 1;
            res_sh_q <= {cell_r, res_sh_q[WIDTH-1:1]};
            bff_q    <= cell_cout;
            cnt_q    <= cnt_q + CNT_W'(1);
            // Publish the result together with the final bit, so diff is valid with done
            if (last_bit) begin
                diff_q   <= {cell_r, res_sh_q[WIDTH-1:1]};
                borrow_q <= cell_cout;
            end
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;

`ifdef RESTA_OVF_EN
    logic ovf_q;

    // Signed overflow: borrow into the MSB differs from borrow out of it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (last_bit && !accept) begin
            ovf_q <= bff_q ^ cell_cout;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_restador_serie.sv
// Self-checking bench for restador_serie: directed cases, back-to-back, reset abort, random.
module tb_restador_serie;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             bin = 1'b0;
    logic             busy, done, borrow;
    logic [WIDTH-1:0] diff;
`ifdef RESTA_OVF_EN
    logic             ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    exp_t sb_q[$];

    restador_serie #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
`ifdef RESTA_OVF_EN
        .borrow (borrow),
        .ovf    (ovf)
`else
        .borrow (borrow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic mbin);
        exp_t e;
        logic [WIDTH:0] u;
        logic [WIDTH:0] s;
        u = {1'b0, ma} - {1'b0, mb} - {{WIDTH{1'b0}}, mbin};
        s = {ma[WIDTH-1], ma} - {mb[WIDTH-1], mb} - {{WIDTH{1'b0}}, mbin};
        e.diff   = u[WIDTH-1:0];
        e.borrow = u[WIDTH];
        e.ovf    = s[WIDTH] ^ s[WIDTH-1];
        return e;
    endfunction

    // Scoreboard: every done pulse pops one expected result
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                check("done_without_op", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("diff", 32'(diff), 32'(e.diff));
                check("borrow", 32'(borrow), 32'(e.borrow));
`ifdef RESTA_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // One isolated operation; returns edges from acceptance to done and busy cycle count
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tbin, output int lat, output int busy_cnt);
        @(negedge clk);
        a = ta; b = tb; bin = tbin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sb_q.push_back(model(ta, tb, tbin));
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 50) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 50) check("done_timeout", 32'(lat), 32'(WIDTH));
        @(negedge clk);
    endtask

    initial begin
        int lat, bc, d0;
        exp_t e;

        // Reset state
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed basics
        run_op(4'd9, 4'd3, 1'b0, lat, bc);
        check("lat_9_3", 32'(lat), 32'(WIDTH));
        check("busy_cycles", 32'(bc), 32'(WIDTH));
        run_op(4'd3, 4'd9, 1'b0, lat, bc);
        run_op(4'd0, 4'd0, 1'b1, lat, bc);
        check("diff_hold_idle", 32'(diff), 32'hF);
        check("borrow_hold_idle", 32'(borrow), 32'd1);

        // Hold start through SHIFT: new operands only accepted in DONE
        @(negedge clk);
        a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        sb_q.push_back(model(4'd9, 4'd3, 1'b0));
        a = 4'd5; b = 4'd1;
        lat = 0;
        while (!done && lat < 50) begin @(posedge clk); #1; lat++; end
        check("b2b_lat1", 32'(lat), 32'(WIDTH));
        sb_q.push_back(model(4'd5, 4'd1, 1'b0));
        lat = 0;
        @(posedge clk); #1;
        start = 1'b0;
        lat++;
        while (!done && lat < 50) begin @(posedge clk); #1; lat++; end
        check("b2b_spacing", 32'(lat), 32'(WIDTH + 1));
        @(negedge clk);
        @(negedge clk);

        // Reset during SHIFT aborts: no done, outputs cleared
        a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("busy_before_abort", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow), 32'd0);
        d0 = n_done;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_no_done", 32'(n_done), 32'(d0));
        run_op(4'd9, 4'd3, 1'b0, lat, bc);
        check("restart_lat", 32'(lat), 32'(WIDTH));

`ifdef RESTA_OVF_EN
        run_op(4'd7, 4'hF, 1'b0, lat, bc);
        run_op(4'd2, 4'd1, 1'b0, lat, bc);
`endif

        // Random regression against the reference model
        for (int i = 0; i < 1000; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), lat, bc);
        end

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("done_total", 32'(n_done), 32'(1000 + 6
`ifdef RESTA_OVF_EN
            + 2
`endif
        ));
        e = model(4'd9, 4'd3, 1'b0);
        check("model_sanity", 32'(diff), 32'(diff));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
